// File: rtl/replace_fifo_pkg.sv
// ----------------------------------------------------------------------------
// replace_fifo_pkg
// Shared constants for the FIFO (round-robin) replacement controller:
//   - request op encodings (OP_LOOKUP, OP_FILL, OP_INVAL; 2'b11 acts as LOOKUP)
//   - flush FSM state encoding (ST_IDLE, ST_FLUSH)
//   - STAT_W, the width of the optional statistics counters
// ----------------------------------------------------------------------------
package replace_fifo_pkg;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    localparam int STAT_W = 32;

endpackage

// File: rtl/replace_fifo_pick.sv
// ----------------------------------------------------------------------------
// replace_fifo_pick
// Combinational victim selection for one set.
//   i_valid   [WAYS-1:0]  valid bit per way
//   i_ptr     [WAY_W-1:0] round-robin victim pointer of the set
//   o_way     [WAY_W-1:0] lowest-index invalid way, else i_ptr
//   o_invalid             1 when o_way is an invalid way
// ----------------------------------------------------------------------------
module replace_fifo_pick #(
    parameter int WAYS  = 4,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  i_valid,
    input  logic [WAY_W-1:0] i_ptr,
    output logic [WAY_W-1:0] o_way,
    output logic             o_invalid
);

    // Scan from the top down so the last hit, i.e. the lowest invalid way, wins.
    always_comb begin
        o_way     = i_ptr;
        o_invalid = 1'b0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_way     = WAY_W'(i);
                o_invalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/replace_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// replace_fifo_ctrl
// FIFO (round-robin) replacement-state controller for one cache array.
// Per set it keeps a valid bit per way and a victim pointer. LOOKUP/FILL/INVAL
// requests update the set and return its victim (post-op) one cycle later.
// A flush FSM clears one set per cycle for SETS cycles.
//
// Ports:
//   fire              clock, rising edge
//   rstn              asynchronous active-low reset
//   i_req_valid       request valid
//   o_req_ready       request accepted when valid & ready at the fire edge
//   i_req_op          00 LOOKUP, 01 FILL, 10 INVAL, 11 LOOKUP
//   i_req_set         target set
//   i_req_way         target way (FILL / INVAL)
//   i_flush           flush request pulse (wins over a same-cycle request)
//   o_flush_busy      flush in progress
//   o_rsp_valid       one-cycle response strobe per accepted request
//   o_rsp_way         victim way of the set after the op
//   o_rsp_invalid     o_rsp_way is an invalid way
//   o_stat_lookups    saturating LOOKUP count
//   o_stat_evictions  saturating count of LOOKUPs on a fully valid set
//
// Configuration: define REPLACE_FIFO_STATS_EN to build the statistics
// counters; otherwise both stat outputs are tied to zero.
// ----------------------------------------------------------------------------
module replace_fifo_ctrl
    import replace_fifo_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int WAYS  = 4,
    parameter int SET_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic              fire,
    input  logic              rstn,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [SET_W-1:0]  i_req_set,
    input  logic [WAY_W-1:0]  i_req_way,
    input  logic              i_flush,
    output logic              o_flush_busy,
    output logic              o_rsp_valid,
    output logic [WAY_W-1:0]  o_rsp_way,
    output logic              o_rsp_invalid,
    output logic [STAT_W-1:0] o_stat_lookups,
    output logic [STAT_W-1:0] o_stat_evictions
);

    logic             r_state;
    logic [SET_W-1:0] r_flush_cnt;
    logic [WAYS-1:0]  r_valid [SETS];
    logic [WAY_W-1:0] r_ptr   [SETS];
    logic             r_rsp_valid;
    logic [WAY_W-1:0] r_rsp_way;
    logic             r_rsp_invalid;

    logic             w_accept;
    logic [WAYS-1:0]  w_cur_valid;
    logic [WAY_W-1:0] w_cur_ptr;
    logic [WAYS-1:0]  w_way_oh;
    logic [WAYS-1:0]  w_next_valid;
    logic [WAY_W-1:0] w_next_ptr;
    logic [WAY_W-1:0] w_pick_way;
    logic             w_pick_invalid;

    assign o_req_ready  = (r_state == ST_IDLE) && !i_flush;
    assign w_accept     = i_req_valid && o_req_ready;
    assign o_flush_busy = (r_state == ST_FLUSH);

    // Post-op view of the addressed set; the response is computed from this
    // so it already reflects the effect of the op being accepted.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_cur_valid  = r_valid[i_req_set];
        w_cur_ptr    = r_ptr[i_req_set];
        w_way_oh     = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (i_req_way == WAY_W'(i)) w_way_oh[i] = 1'b1;
        end
        w_next_valid = w_cur_valid;
        w_next_ptr   = w_cur_ptr;
        case (i_req_op)
            OP_FILL: begin
                w_next_valid = w_cur_valid | w_way_oh;
                // Only filling the pointed-at way advances the FIFO order.
                if (i_req_way == w_cur_ptr) begin
                    w_next_ptr = (w_cur_ptr == WAY_W'(WAYS - 1)) ? '0 : w_cur_ptr + WAY_W'(1);
                end
            end
            OP_INVAL: w_next_valid = w_cur_valid & ~w_way_oh;
            default:  ;
        endcase
    end

    replace_fifo_pick #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_pick (
        .i_valid   (w_next_valid),
        .i_ptr     (w_next_ptr),
        .o_way     (w_pick_way),
        .o_invalid (w_pick_invalid)
    );

    // NOTE: state arrays are flops, not RAM, so they take the async reset like any register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge fire or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_flush_cnt   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_way     <= '0;
            r_rsp_invalid <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_flush) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= '0;
                    end else if (w_accept) begin
                        r_valid[i_req_set] <= w_next_valid;
                        r_ptr[i_req_set]   <= w_next_ptr;
                        r_rsp_valid        <= 1'b1;
                        r_rsp_way          <= w_pick_way;
                        r_rsp_invalid      <= w_pick_invalid;
                    end
                end
                ST_FLUSH: begin
                    r_valid[r_flush_cnt] <= '0;
                    r_ptr[r_flush_cnt]   <= '0;
                    if (r_flush_cnt == SET_W'(SETS - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + SET_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_way     = r_rsp_way;
    assign o_rsp_invalid = r_rsp_invalid;

`ifdef REPLACE_FIFO_STATS_EN
    logic [STAT_W-1:0] r_stat_lookups;
    logic [STAT_W-1:0] r_stat_evictions;
    logic              w_is_lookup;

    // Op 2'b11 is counted as a LOOKUP, matching its behaviour.
    assign w_is_lookup = w_accept && (i_req_op != OP_FILL) && (i_req_op != OP_INVAL);

    // Counters saturate at all-ones and survive a flush; only reset clears them.
    always_ff @(posedge fire or negedge rstn) begin
        if (!rstn) begin
            r_stat_lookups   <= '0;
            r_stat_evictions <= '0;
        end else if (w_is_lookup) begin
            if (r_stat_lookups != '1) r_stat_lookups <= r_stat_lookups + STAT_W'(1);
            if ((&w_cur_valid) && (r_stat_evictions != '1)) begin
                r_stat_evictions <= r_stat_evictions + STAT_W'(1);
            end
        end
    end

    assign o_stat_lookups   = r_stat_lookups;
    assign o_stat_evictions = r_stat_evictions;
`else
    assign o_stat_lookups   = '0;
    assign o_stat_evictions = '0;
`endif

endmodule

// File: tb/tb_replace_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_replace_fifo_ctrl
// Self-checking bench for replace_fifo_ctrl (SETS=16, WAYS=4): directed
// scenarios followed by randomized traffic, compared against a reference
// model that tracks per-set valid bits and a FIFO pointer as plain arrays.
// Statistic expectations follow REPLACE_FIFO_STATS_EN.
// ----------------------------------------------------------------------------
module tb_replace_fifo_ctrl;

    localparam int SETS  = 16;
    localparam int WAYS  = 4;
    localparam int SET_W = 4;
    localparam int WAY_W = 2;

    logic             fire = 1'b0;
    logic             rstn = 1'b0;
    logic             i_req_valid = 1'b0;
    logic             o_req_ready;
    logic [1:0]       i_req_op = 2'b00;
    logic [SET_W-1:0] i_req_set = '0;
    logic [WAY_W-1:0] i_req_way = '0;
    logic             i_flush = 1'b0;
    logic             o_flush_busy;
    logic             o_rsp_valid;
    logic [WAY_W-1:0] o_rsp_way;
    logic             o_rsp_invalid;
    logic [31:0]      o_stat_lookups;
    logic [31:0]      o_stat_evictions;

    replace_fifo_ctrl #(.SETS(SETS), .WAYS(WAYS)) dut (
        .fire             (fire),
        .rstn             (rstn),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_op         (i_req_op),
        .i_req_set        (i_req_set),
        .i_req_way        (i_req_way),
        .i_flush          (i_flush),
        .o_flush_busy     (o_flush_busy),
        .o_rsp_valid      (o_rsp_valid),
        .o_rsp_way        (o_rsp_way),
        .o_rsp_invalid    (o_rsp_invalid),
        .o_stat_lookups   (o_stat_lookups),
        .o_stat_evictions (o_stat_evictions)
    );

    always #5 fire = ~fire;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-set valid flags and FIFO pointer, plus stat counts.
    bit m_valid [SETS][WAYS];
    int m_ptr   [SETS];
    int m_lookups;
    int m_evicts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic model_reset();
        model_flush();
        m_lookups = 0;
        m_evicts  = 0;
    endtask

    // Issue one request (valid stays high so successive calls are back-to-back).
    task automatic do_op(input logic [1:0] op, input int s, input int w);
        int exp_way;
        bit exp_inv;
        bit full;
        i_flush     = 1'b0;
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_set   = SET_W'(s);
        i_req_way   = WAY_W'(w);
        #1;
        check("req_ready", o_req_ready, 1);
        if (op == 2'b01) begin
            m_valid[s][w] = 1'b1;
            if (w == m_ptr[s]) m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end else if (op == 2'b10) begin
            m_valid[s][w] = 1'b0;
        end else begin
            full = 1'b1;
            for (int i = 0; i < WAYS; i++) if (!m_valid[s][i]) full = 1'b0;
            m_lookups++;
            if (full) m_evicts++;
        end
        exp_inv = 1'b0;
        exp_way = m_ptr[s];
        for (int i = 0; i < WAYS; i++) begin
            if (!m_valid[s][i] && !exp_inv) begin
                exp_way = i;
                exp_inv = 1'b1;
            end
        end
        @(posedge fire);
        #1;
        check("rsp_valid", o_rsp_valid, 1);
        check("rsp_way", o_rsp_way, exp_way);
        check("rsp_invalid", o_rsp_invalid, exp_inv);
    endtask

    task automatic idle_cycle();
        i_req_valid = 1'b0;
        i_flush     = 1'b0;
        @(posedge fire);
        #1;
        check("rsp_valid_idle", o_rsp_valid, 0);
    endtask

    // Flush pulse; optionally hold a request valid throughout, which must be ignored.
    task automatic do_flush(input bit hold_req);
        i_flush     = 1'b1;
        i_req_valid = hold_req;
        i_req_op    = 2'b00;
        #1;
        check("ready_flush_wins", o_req_ready, 0);
        @(posedge fire);
        #1;
        model_flush();
        for (int c = 0; c < SETS; c++) begin
            check("flush_busy", o_flush_busy, 1);
            check("flush_ready", o_req_ready, 0);
            check("flush_no_rsp", o_rsp_valid, 0);
            i_flush = (c == 3);
            if (c == SETS - 1) i_req_valid = 1'b0;
            @(posedge fire);
            #1;
        end
        i_flush = 1'b0;
        check("flush_done_busy", o_flush_busy, 0);
        check("flush_done_ready", o_req_ready, 1);
        check("flush_done_rsp", o_rsp_valid, 0);
    endtask

    task automatic check_stats(input string tag);
`ifdef REPLACE_FIFO_STATS_EN
        check({tag, "_lookups"}, o_stat_lookups, m_lookups);
        check({tag, "_evictions"}, o_stat_evictions, m_evicts);
`else
        check({tag, "_lookups"}, o_stat_lookups, 0);
        check({tag, "_evictions"}, o_stat_evictions, 0);
`endif
    endtask

    task automatic release_reset();
        repeat (2) @(posedge fire);
        #1;
        rstn = 1'b1;
        model_reset();
        @(posedge fire);
        #1;
        check("ready_after_reset", o_req_ready, 1);
    endtask

    initial begin
        model_reset();
        // Reset values
        #2;
        check("reset_busy", o_flush_busy, 0);
        check("reset_rsp_valid", o_rsp_valid, 0);
        check("reset_rsp_way", o_rsp_way, 0);
        check("reset_rsp_invalid", o_rsp_invalid, 0);
        check("reset_stat_lookups", o_stat_lookups, 0);
        check("reset_stat_evictions", o_stat_evictions, 0);
        release_reset();

        // 1: lookup on an empty set, then the strobe lasts a single cycle
        do_op(2'b00, 3, 0);
        idle_cycle();

        // 2: fill all ways, lookup, then FIFO wrap on refills
        for (int w = 0; w < WAYS; w++) do_op(2'b01, 3, w);
        do_op(2'b00, 3, 0);
        for (int w = 0; w < WAYS; w++) do_op(2'b01, 3, w);

        // 3: invalidate inside a full set, then refill it
        do_op(2'b10, 3, 2);
        do_op(2'b01, 3, 2);
        do_op(2'b11, 3, 1);
        idle_cycle();

        // 4: flush with a request held valid throughout
        do_flush(1'b1);
        do_op(2'b00, 3, 0);
        idle_cycle();

        // 5a: reset right after an accepted op clears the response at once
        do_op(2'b01, 7, 0);
        rstn = 1'b0;
        #1;
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_way", o_rsp_way, 0);
        release_reset();

        // 5b: reset in flush cycle 5
        for (int w = 0; w < WAYS; w++) do_op(2'b01, 9, w);
        i_req_valid = 1'b0;
        i_flush     = 1'b1;
        @(posedge fire);
        #1;
        i_flush = 1'b0;
        repeat (4) @(posedge fire);
        #1;
        check("mid_flush_busy", o_flush_busy, 1);
        rstn = 1'b0;
        #1;
        check("rst_flush_busy", o_flush_busy, 0);
        check("rst_flush_rsp", o_rsp_valid, 0);
        release_reset();
        for (int s = 0; s < SETS; s++) do_op(2'b00, s, 0);
        idle_cycle();

        // 6: statistics after a reset
        rstn = 1'b0;
        #1;
        release_reset();
        for (int w = 0; w < WAYS; w++) do_op(2'b01, 5, w);
        for (int k = 0; k < 3; k++) do_op(2'b00, 5, 0);
        do_op(2'b00, 6, 0);
        idle_cycle();
        check_stats("stats_directed");

        // Randomized traffic on a few sets so collisions are frequent
        for (int n = 0; n < 500; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)       do_flush(r[0]);
            else if (r < 12) idle_cycle();
            else do_op(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, WAYS - 1));
        end
        idle_cycle();
        check_stats("stats_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
